// File: rtl/m_uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte queue.
// UART_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO; without it a single holding register is used.
module m_uart_tx_fifo #(
    parameter int TX_COUNT   = 50,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        w_clk,
    input  logic                        w_rst,
    input  logic                        w_we,
    input  logic [7:0]                  w_din,
    output logic                        w_txd,
    output logic                        r_full,
    output logic                        r_empty,
    output logic                        r_busy,
    output logic                        r_ovf,
    output logic [$clog2(FIFO_DEPTH):0] r_level
);

    // state | meaning
    // IDLE  | line high, waiting for a queued byte
    // START | start bit (0) for TX_COUNT cycles
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (1); pops the next byte at its end if one is queued

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (TX_COUNT > 1) ? $clog2(TX_COUNT) : 1;
`ifdef UART_TX_FIFO_EN
    localparam logic [LW-1:0] LVL_MAX = LW'(FIFO_DEPTH);
`else
    localparam logic [LW-1:0] LVL_MAX = LW'(1);
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     head;
    logic           cnt_tc;
    logic           push;
    logic           pop;
    logic [LW-1:0]  level_nxt;

    assign cnt_tc = (cnt == CW'(TX_COUNT - 1));
    assign push   = w_we && !r_full;

    always_comb begin
        pop = 1'b0;
        if (!r_empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == STOP && cnt_tc)
                pop = 1'b1;
        end
    end

    assign level_nxt = r_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef UART_TX_FIFO_EN
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge w_clk) begin
        if (push)
            mem[wr_ptr] <= w_din;
    end
`else
    logic [7:0] hold_q;

    assign head = hold_q;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst)
            hold_q <= '0;
        else if (push)
            hold_q <= w_din;
    end
`endif

    // Flags are computed from the next level so they line up with r_level.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_level <= level_nxt;
            r_full  <= (level_nxt == LVL_MAX);
            r_empty <= (level_nxt == '0);
            if (w_we && r_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            w_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!r_empty) begin
                        state  <= START;
                        shreg  <= head;
                        w_txd  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_tc) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                        w_txd   <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_tc) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            w_txd <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            w_txd   <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_tc) begin
                        cnt <= '0;
                        if (!r_empty) begin
                            state <= START;
                            shreg <= head;
                            w_txd <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            r_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    w_txd  <= 1'b1;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
